// File: rtl/pio_exec_control.sv
// Execute/sequencing unit for one PIO state machine: decode, X/Y scratch, JMP/WAIT/SET, delay cycles.
// Optional build macro PIO_SIDESET_EN adds a registered 2-bit side_set output and shrinks delay to 3 bits.
module pio_exec_control #(
    parameter int unsigned NUM_PINS = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sm_en,
    input  logic [15:0]         instr,
    input  logic [NUM_PINS-1:0] pins,
    input  logic [4:0]          jmp_pin_sel,
    input  logic                osr_empty,
    input  logic [7:0]          irq_flags,
    output logic [7:0]          irq_clear,
    output logic [4:0]          jump,
    output logic                jump_en,
    output logic                pc_en,
    output logic [DATA_W-1:0]   x,
    output logic [DATA_W-1:0]   y,
`ifdef PIO_SIDESET_EN
    output logic [1:0]          side_set,
`endif
    output logic                busy
);

    localparam int unsigned DLY_W = 5;

    localparam logic [2:0] OP_JMP  = 3'b000;
    localparam logic [2:0] OP_WAIT = 3'b001;
    localparam logic [2:0] OP_SET  = 3'b111;

    typedef enum logic {
        EXEC  = 1'b0,
        DELAY = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [DLY_W-1:0]    dly_cnt, dly_nxt;
    logic [DATA_W-1:0]   x_nxt, y_nxt;

    logic [2:0]          op;
    logic [DLY_W-1:0]    d;
    logic [2:0]          cond;
    logic [4:0]          idx;
    logic [1:0]          src;
    logic                pol;
    logic                sampled;
    logic                stall;
    logic                cond_true;
    logic                complete;

    assign op   = instr[15:13];
    assign cond = instr[7:5];
    assign idx  = instr[4:0];
    assign src  = instr[6:5];
    assign pol  = instr[7];

`ifdef PIO_SIDESET_EN
    assign d = DLY_W'(instr[10:8]);
`else
    assign d = instr[12:8];
`endif

    // Condition / wait evaluation, control outputs, side effects and next state
    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        x_nxt     = x;
        y_nxt     = y;
        sampled   = 1'b0;
        cond_true = 1'b0;
        stall     = 1'b0;
        complete  = 1'b0;
        pc_en     = 1'b0;
        jump_en   = 1'b0;
        jump      = 5'd0;
        busy      = 1'b0;
        irq_clear = 8'd0;

        unique case (cond)
            3'b000: cond_true = 1'b1;
            3'b001: cond_true = (x == '0);
            3'b010: cond_true = (x != '0);
            3'b011: cond_true = (y == '0);
            3'b100: cond_true = (y != '0);
            3'b101: cond_true = (x != y);
            3'b110: cond_true = pins[jmp_pin_sel];
            default: cond_true = ~osr_empty;
        endcase

        unique case (src)
            2'b00, 2'b01: sampled = pins[idx];
            2'b10:        sampled = irq_flags[idx[2:0]];
            default:      sampled = pol;   // reserved source never stalls
        endcase

        stall    = (op == OP_WAIT) && (sampled != pol);
        complete = sm_en && (state == EXEC) && !stall;

        if (!rst) begin
            if (state == EXEC) begin
                busy    = stall;
                pc_en   = sm_en & ~stall;
                jump    = (op == OP_JMP) ? idx : 5'd0;
                jump_en = pc_en & (op == OP_JMP) & cond_true;
                if (complete && op == OP_WAIT && src == 2'b10 && pol)
                    irq_clear[idx[2:0]] = 1'b1;
            end else begin
                busy = 1'b1;
            end
        end

        // Scratch-register side effects land only on the completing edge
        if (complete) begin
            if (op == OP_JMP && cond == 3'b010) x_nxt = x - DATA_W'(1);
            if (op == OP_JMP && cond == 3'b100) y_nxt = y - DATA_W'(1);
            if (op == OP_SET && cond == 3'b001) x_nxt = DATA_W'(idx);
            if (op == OP_SET && cond == 3'b010) y_nxt = DATA_W'(idx);
        end

        if (sm_en) begin
            unique case (state)
                EXEC: begin
                    if (complete && d != '0) begin
                        state_nxt = DELAY;
                        dly_nxt   = d;
                    end
                end
                default: begin
                    if (dly_cnt == DLY_W'(1)) begin
                        state_nxt = EXEC;
                        dly_nxt   = '0;
                    end else begin
                        dly_nxt = dly_cnt - DLY_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EXEC;
            dly_cnt <= '0;
            x       <= '0;
            y       <= '0;
        end else begin
            state   <= state_nxt;
            dly_cnt <= dly_nxt;
            x       <= x_nxt;
            y       <= y_nxt;
        end
    end

`ifdef PIO_SIDESET_EN
    // first_exec marks the opening EXEC cycle of an instruction, stalled or not
    logic first_exec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_exec <= 1'b1;
            side_set   <= 2'b00;
        end else if (sm_en && state == EXEC) begin
            first_exec <= complete;
            if (first_exec) side_set <= instr[12:11];
        end
    end
`endif

endmodule

// File: tb/tb_pio_exec_control.sv
// Directed bench for pio_exec_control: expected outputs are queued with each stimulus step
// and popped/compared shortly after the inputs settle.
module tb_pio_exec_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        sm_en;
    logic [15:0] instr;
    logic [31:0] pins;
    logic [4:0]  jmp_pin_sel;
    logic        osr_empty;
    logic [7:0]  irq_flags;
    logic [7:0]  irq_clear;
    logic [4:0]  jump;
    logic        jump_en;
    logic        pc_en;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    typedef struct {
        logic        pc_en;
        logic        jump_en;
        logic [4:0]  jump;
        logic        busy;
        logic [7:0]  irq_clear;
        logic [31:0] x;
        logic [31:0] y;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    pio_exec_control #(.NUM_PINS(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .sm_en       (sm_en),
        .instr       (instr),
        .pins        (pins),
        .jmp_pin_sel (jmp_pin_sel),
        .osr_empty   (osr_empty),
        .irq_flags   (irq_flags),
        .irq_clear   (irq_clear),
        .jump        (jump),
        .jump_en     (jump_en),
        .pc_en       (pc_en),
        .x           (x),
        .y           (y),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Drive instr at a negedge, queue the expectation, compare 1ns later, then move to the next negedge.
    task automatic step(input string tag, input logic [15:0] i,
                        input logic e_pc, input logic e_je, input logic [4:0] e_j,
                        input logic e_busy, input logic [7:0] e_irq,
                        input logic [31:0] e_x, input logic [31:0] e_y);
        exp_t e;
        string t;
        instr = i;
        exp_q.push_back('{e_pc, e_je, e_j, e_busy, e_irq, e_x, e_y});
        tag_q.push_back(tag);
        #1;
        n_tests++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed none, expected one entry", tag);
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        assert (pc_en === e.pc_en) else begin
            n_fail++; $error("FAIL %s pc_en: observed %b expected %b", t, pc_en, e.pc_en);
        end
        n_tests++;
        assert (jump_en === e.jump_en) else begin
            n_fail++; $error("FAIL %s jump_en: observed %b expected %b", t, jump_en, e.jump_en);
        end
        n_tests++;
        assert (jump === e.jump) else begin
            n_fail++; $error("FAIL %s jump: observed %0d expected %0d", t, jump, e.jump);
        end
        n_tests++;
        assert (busy === e.busy) else begin
            n_fail++; $error("FAIL %s busy: observed %b expected %b", t, busy, e.busy);
        end
        n_tests++;
        assert (irq_clear === e.irq_clear) else begin
            n_fail++; $error("FAIL %s irq_clear: observed %h expected %h", t, irq_clear, e.irq_clear);
        end
        n_tests++;
        assert (x === e.x) else begin
            n_fail++; $error("FAIL %s x: observed %h expected %h", t, x, e.x);
        end
        n_tests++;
        assert (y === e.y) else begin
            n_fail++; $error("FAIL %s y: observed %h expected %h", t, y, e.y);
        end
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        sm_en       = 1'b1;
        instr       = 16'h0000;
        pins        = 32'd0;
        jmp_pin_sel = 5'd7;
        osr_empty   = 1'b0;
        irq_flags   = 8'd0;
        @(negedge clk);

        // Reset held for two cycles
        step("rst0", 16'h0000, 0, 0, 0, 0, 8'h00, 0, 0);
        step("rst1", 16'h0000, 0, 0, 0, 0, 8'h00, 0, 0);
        rst = 1'b0;
        step("rel",  16'h0000, 1, 1, 0, 0, 8'h00, 0, 0);

        // SET X=5 then JMP X-- loop
        step("setx5", 16'hE025, 1, 0, 0, 0, 8'h00, 0, 0);
        step("jx5",   16'h0043, 1, 1, 3, 0, 8'h00, 5, 0);
        step("jx4",   16'h0043, 1, 1, 3, 0, 8'h00, 4, 0);
        step("jx3",   16'h0043, 1, 1, 3, 0, 8'h00, 3, 0);
        step("jx2",   16'h0043, 1, 1, 3, 0, 8'h00, 2, 0);
        step("jx1",   16'h0043, 1, 1, 3, 0, 8'h00, 1, 0);
        step("jx0",   16'h0043, 1, 0, 3, 0, 8'h00, 0, 0);

        // Remaining JMP conditions
        step("sety0", 16'hE040, 1, 0, 0, 0, 8'h00, ONES, 0);
        step("jy0",   16'h0083, 1, 0, 3, 0, 8'h00, ONES, 0);
        step("jxney", 16'h00A7, 1, 0, 7, 0, 8'h00, ONES, ONES);
        step("jxz",   16'h0021, 1, 0, 1, 0, 8'h00, ONES, ONES);
        step("jyz",   16'h0061, 1, 0, 1, 0, 8'h00, ONES, ONES);
        step("setx7", 16'hE027, 1, 0, 0, 0, 8'h00, ONES, ONES);
        step("jxne2", 16'h00A7, 1, 1, 7, 0, 8'h00, 7, ONES);
        pins = 32'h0000_0080;
        step("jpin1", 16'h00C5, 1, 1, 5, 0, 8'h00, 7, ONES);
        pins = 32'd0;
        step("jpin0", 16'h00C5, 1, 0, 5, 0, 8'h00, 7, ONES);
        osr_empty = 1'b1;
        step("josr1", 16'h00E6, 1, 0, 6, 0, 8'h00, 7, ONES);
        osr_empty = 1'b0;
        step("josr0", 16'h00E6, 1, 1, 6, 0, 8'h00, 7, ONES);

        // NOP with delay 3
        step("nopd3", 16'hA300, 1, 0, 0, 0, 8'h00, 7, ONES);
        for (int k = 0; k < 3; k++)
            step("dly", 16'h4000, 0, 0, 0, 1, 8'h00, 7, ONES);
        step("dlyend", 16'h4000, 1, 0, 0, 0, 8'h00, 7, ONES);

        // JMP with delay jumps first, then delays
        step("jmpd3", 16'h0305, 1, 1, 5, 0, 8'h00, 7, ONES);
        for (int k = 0; k < 3; k++)
            step("jdly", 16'h4000, 0, 0, 0, 1, 8'h00, 7, ONES);
        step("jdlyend", 16'h4000, 1, 0, 0, 0, 8'h00, 7, ONES);

        // WAIT pin 4 high
        for (int k = 0; k < 5; k++)
            step("wpin_stall", 16'h2084, 0, 0, 0, 1, 8'h00, 7, ONES);
        pins = 32'h0000_0010;
        step("wpin_go", 16'h2084, 1, 0, 0, 0, 8'h00, 7, ONES);
        pins = 32'd0;

        // WAIT IRQ 2 high, already set: completes and clears for one cycle
        irq_flags = 8'h04;
        step("wirq", 16'h20C2, 1, 0, 0, 0, 8'h04, 7, ONES);
        irq_flags = 8'h00;
        step("wirq_after", 16'h4000, 1, 0, 0, 0, 8'h00, 7, ONES);

        // WAIT IRQ 2 low: stalls while flag set, no clear
        irq_flags = 8'h04;
        step("wirq0_stall", 16'h2042, 0, 0, 0, 1, 8'h00, 7, ONES);
        irq_flags = 8'h00;
        step("wirq0_go", 16'h2042, 1, 0, 0, 0, 8'h00, 7, ONES);

        // sm_en=0 in EXEC freezes X
        sm_en = 1'b0;
        step("dis_set0", 16'hE029, 0, 0, 0, 0, 8'h00, 7, ONES);
        step("dis_set1", 16'hE029, 0, 0, 0, 0, 8'h00, 7, ONES);
        sm_en = 1'b1;
        step("en_nop", 16'h4000, 1, 0, 0, 0, 8'h00, 7, ONES);

        // Disable for 4 cycles with two delay cycles remaining
        step("en_d3", 16'hA300, 1, 0, 0, 0, 8'h00, 7, ONES);
        step("en_dly3", 16'h4000, 0, 0, 0, 1, 8'h00, 7, ONES);
        sm_en = 1'b0;
        for (int k = 0; k < 4; k++)
            step("en_hold", 16'h4000, 0, 0, 0, 1, 8'h00, 7, ONES);
        sm_en = 1'b1;
        step("en_dly2", 16'h4000, 0, 0, 0, 1, 8'h00, 7, ONES);
        step("en_dly1", 16'h4000, 0, 0, 0, 1, 8'h00, 7, ONES);
        step("en_done", 16'h4000, 1, 0, 0, 0, 8'h00, 7, ONES);

        // Reset mid-DELAY returns to EXEC
        step("r_d3", 16'hA300, 1, 0, 0, 0, 8'h00, 7, ONES);
        step("r_dly", 16'h4000, 0, 0, 0, 1, 8'h00, 7, ONES);
        rst = 1'b1;
        step("r_rst", 16'h4000, 0, 0, 0, 0, 8'h00, 0, 0);
        rst = 1'b0;
        step("r_exec", 16'h0000, 1, 1, 0, 0, 8'h00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_exec_control.md
Name: pio_exec_control

Overview:
Execute/sequencing unit for one PIO state machine. It sits on the other side of the program counter's control interface.
- Consumes the instruction word fetched at the current pc.
- Drives the jump/jump_en/pc_en controls that advance the program counter.
- Owns the X/Y scratch registers, JMP condition evaluation, WAIT stalls and post-instruction delay cycles.

Parameters:
NUM_PINS, 32, width of GPIO input bus sampled by JMP PIN / WAIT GPIO
DATA_W, 32, width of X and Y scratch registers

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
sm_en  input  1  state machine enable; 0 freezes all state, pc_en=0
instr  input  16  instruction word at current pc (combinational from instruction memory)
pins  input  NUM_PINS  GPIO input values
jmp_pin_sel  input  5  pin index used by JMP PIN condition
osr_empty  input  1  output shift register empty flag (JMP !OSRE)
irq_flags  input  8  IRQ flag inputs for WAIT IRQ
irq_clear  output  8  one-cycle clear pulse for the satisfied IRQ flag
jump  output  5  jump target to program counter
jump_en  output  1  take jump this cycle
pc_en  output  1  advance/load program counter this cycle
x  output  DATA_W  scratch X
y  output  DATA_W  scratch Y
busy  output  1  high while in DELAY state or WAIT-stalled

Behaviour:
- Reset (async): state=EXEC, dly_cnt=0, x=0, y=0. While rst is high, jump=0, jump_en=0, pc_en=0, irq_clear=0, busy=0. Reset mid-DELAY or mid-WAIT aborts to EXEC.
- Decode: op=instr[15:13]; delay field d=instr[12:8] (0-31); operand fields in instr[7:0].
- States: EXEC, DELAY.
- EXEC: instruction completes this cycle unless WAIT-stalled. pc_en = sm_en & ~stall; all outputs are combinational from instr and state.
  - On completion with d>0: go to DELAY with dly_cnt=d.
  - On completion with d=0: stay in EXEC.
- DELAY: pc_en=0, jump_en=0, busy=1; instr is ignored (pc already advanced).
  - dly_cnt decrements each enabled cycle.
  - When dly_cnt==1 at the clock edge, go to EXEC.
  - Total instruction time is 1+d cycles.
- JMP (000): cond=instr[7:5], target=instr[4:0]. jump=target; jump_en=pc_en & cond_true. Conditions:
  - 000 always
  - 001 X==0
  - 010 X!=0, then X<=X-1 regardless of outcome (0 wraps to all-ones)
  - 011 Y==0
  - 100 Y!=0, then Y<=Y-1 as for X
  - 101 X!=Y
  - 110 pins[jmp_pin_sel]==1
  - 111 osr_empty==0
- When the JMP is not taken, the program counter's normal increment/wrap applies. jump is driven with target whenever op=JMP, else 0.
- WAIT (001): pol=instr[7], src=instr[6:5], idx=instr[4:0]. stall = ~(sampled == pol).
  - src 00/01: sampled=pins[idx].
  - src 10: sampled=irq_flags[idx[2:0]]; when satisfied with pol=1, irq_clear[idx[2:0]]=1 for that cycle.
  - src 11: reserved, never stalls.
  - While stalled: pc_en=0, busy=1, the delay has not started, and side effects are held off.
- SET (111): dest=instr[7:5]; 001 X<=zero-extended instr[4:0]; 010 Y<= same; other destinations are NOP.
- All other opcodes: NOP with delay honoured.
- Side effects (X/Y writes, decrements) occur only on the completing EXEC edge with sm_en=1.
- sm_en=0: pc_en=0, jump_en=0, irq_clear=0; state, dly_cnt, X and Y frozen; resumes exactly where it stopped.
- Simultaneous events: a WAIT satisfied in the same cycle it is decoded completes with no stall. A JMP with d>0 jumps on the EXEC cycle, then delays.

Optional Feature:
PIO_SIDESET_EN.
- Defined: adds output side_set[1:0]. instr[12:11] is side-set data; delay becomes instr[10:8] (0-7). side_set is registered, reset 0, and loaded on the first EXEC cycle of each instruction, including WAIT-stalled cycles.
- Not defined: no side_set port; 5-bit delay as above.

Test Plan:
- Reset: rst=1 for 2 cycles, instr=16'h0000 -> pc_en=0, x=y=0, state EXEC. Release -> pc_en=1, jump_en=1, jump=0.
- SET X=5 (16'hE025), then JMP X-- to 3 (16'h0043) repeated -> jump_en=1 for X=5,4,3,2,1; sixth pass jump_en=0; X ends at 32'hFFFFFFFF.
- Delay: NOP with d=3 (16'hA300) -> pc_en=1 on cycle 0, then 0 for 3 cycles with busy=1, then pc_en=1 for the next instruction.
- WAIT pin 4 high (16'h2084), pins[4]=0 for 5 cycles then 1 -> pc_en=0 and busy=1 for 5 cycles; pc_en=1 on the cycle pins[4] rises.
- WAIT IRQ 2 high (16'h20C2), irq_flags=8'h04 -> no stall; irq_clear=8'h04 for exactly 1 cycle.
- Enable/reset: sm_en=0 mid-DELAY (dly_cnt=2) for 4 cycles -> dly_cnt holds and pc_en=0; after re-enable, 2 more delay cycles. Assert rst mid-DELAY -> EXEC immediately.
